// File: rtl/regfile_writeback_unit_if.sv
// rtl/regfile_writeback_unit_if.sv - ALU/load/decode/regfile signal bundle for the writeback unit
interface regfile_writeback_unit_if;
  logic        alu_valid;
  logic [4:0]  alu_rd_address;
  logic [31:0] alu_result;
  logic        load_issue;
  logic [4:0]  load_issue_address;
  logic        load_valid;
  logic [4:0]  load_rd_address;
  logic [31:0] load_data;
  logic        load_ready;
  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic        hazard;
  logic [31:0] busy_vector;
  logic [31:0] rd;
  logic [4:0]  rd_address;
  logic        rd_write_enable;
  logic        waw_error;

  modport master (
    output alu_valid, alu_rd_address, alu_result,
    output load_issue, load_issue_address,
    output load_valid, load_rd_address, load_data,
    output rs1_address, rs2_address,
    input  load_ready, hazard, busy_vector,
    input  rd, rd_address, rd_write_enable, waw_error
  );

  modport slave (
    input  alu_valid, alu_rd_address, alu_result,
    input  load_issue, load_issue_address,
    input  load_valid, load_rd_address, load_data,
    input  rs1_address, rs2_address,
    output load_ready, hazard, busy_vector,
    output rd, rd_address, rd_write_enable, waw_error
  );
endinterface

// File: rtl/regfile_writeback_unit.sv
// rtl/regfile_writeback_unit.sv - regfile write-port arbiter with load skid buffer and pending-load scoreboard
module regfile_writeback_unit #(
  parameter int RV32I = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_writeback_unit_if.slave wb
);
  localparam logic [4:0]  ADDR_MASK = (RV32I != 0) ? 5'h1f : 5'h0f;
  localparam logic [31:0] BUSY_MASK = (RV32I != 0) ? 32'hffff_ffff : 32'h0000_ffff;

  logic [4:0]  alu_addr, issue_addr, ret_addr, rs1_addr, rs2_addr;
  logic        skid_valid;
  logic [4:0]  skid_addr;
  logic [31:0] skid_data;
  logic [31:0] busy_q, busy_next;
  logic [31:0] rd_q;
  logic [4:0]  rd_addr_q;
  logic        rd_we_q, wb_is_load_q, waw_q;
  logic        load_ready, load_accept;
  logic        alu_blocked, issue_conflict, ret_unexpected;
  logic        win_en, win_load, skid_fill, skid_drain;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  assign alu_addr   = wb.alu_rd_address & ADDR_MASK;
  assign issue_addr = wb.load_issue_address & ADDR_MASK;
  assign ret_addr   = wb.load_rd_address & ADDR_MASK;
  assign rs1_addr   = wb.rs1_address & ADDR_MASK;
  assign rs2_addr   = wb.rs2_address & ADDR_MASK;

  assign load_ready  = reset && !skid_valid;
  assign load_accept = wb.load_valid && load_ready;

  // x0 is never marked busy, so these checks need no explicit x0 exclusion except for returns
  assign alu_blocked    = wb.alu_valid && busy_q[alu_addr];
  assign issue_conflict = wb.load_issue && (issue_addr != 5'd0) && busy_q[issue_addr];
  assign ret_unexpected = load_accept && (ret_addr != 5'd0) && !busy_q[ret_addr];

  always_comb begin
    win_en     = 1'b0;
    win_load   = 1'b0;
    win_addr   = ret_addr;
    win_data   = wb.load_data;
    skid_fill  = 1'b0;
    skid_drain = 1'b0;
    if (wb.alu_valid) begin
      win_en    = !alu_blocked && (alu_addr != 5'd0);
      win_addr  = alu_addr;
      win_data  = wb.alu_result;
      skid_fill = load_accept;
    end else if (skid_valid) begin
      win_en     = (skid_addr != 5'd0);
      win_load   = 1'b1;
      win_addr   = skid_addr;
      win_data   = skid_data;
      skid_drain = 1'b1;
    end else if (load_accept) begin
      win_en   = (ret_addr != 5'd0);
      win_load = 1'b1;
    end
  end

  // Clear follows the commit edge of a load writeback; a same-edge re-issue keeps the bit set
  always_comb begin
    busy_next = busy_q;
    if (rd_we_q && wb_is_load_q)
      busy_next[rd_addr_q] = 1'b0;
    if (wb.load_issue && (issue_addr != 5'd0))
      busy_next[issue_addr] = 1'b1;
    busy_next = busy_next & BUSY_MASK;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q       <= '0;
      skid_valid   <= 1'b0;
      skid_addr    <= '0;
      skid_data    <= '0;
      rd_q         <= '0;
      rd_addr_q    <= '0;
      rd_we_q      <= 1'b0;
      wb_is_load_q <= 1'b0;
      waw_q        <= 1'b0;
    end else begin
      busy_q <= busy_next;
      if (skid_fill) begin
        skid_valid <= 1'b1;
        skid_addr  <= ret_addr;
        skid_data  <= wb.load_data;
      end else if (skid_drain) begin
        skid_valid <= 1'b0;
      end
      rd_we_q      <= win_en;
      wb_is_load_q <= win_load;
      if (win_en) begin
        rd_q      <= win_data;
        rd_addr_q <= win_addr;
      end
      if (alu_blocked || issue_conflict || ret_unexpected)
        waw_q <= 1'b1;
    end
  end

  assign wb.load_ready      = load_ready;
  assign wb.hazard          = ((rs1_addr != 5'd0) && busy_q[rs1_addr]) ||
                              ((rs2_addr != 5'd0) && busy_q[rs2_addr]);
  assign wb.busy_vector     = busy_q;
  assign wb.rd              = rd_q;
  assign wb.rd_address      = rd_addr_q;
  assign wb.rd_write_enable = rd_we_q;
  assign wb.waw_error       = waw_q;
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb/tb_regfile_writeback_unit.sv - directed and randomized bench for regfile_writeback_unit
module tb_regfile_writeback_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  regfile_writeback_unit_if ifa();
  regfile_writeback_unit_if ife();

  regfile_writeback_unit #(.RV32I(1)) dut_a (.clock(clock), .reset(reset), .wb(ifa.slave));
  regfile_writeback_unit #(.RV32I(0)) dut_e (.clock(clock), .reset(reset), .wb(ife.slave));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_a();
    ifa.alu_valid = 0; ifa.alu_rd_address = 0; ifa.alu_result = 0;
    ifa.load_issue = 0; ifa.load_issue_address = 0;
    ifa.load_valid = 0; ifa.load_rd_address = 0; ifa.load_data = 0;
    ifa.rs1_address = 0; ifa.rs2_address = 0;
  endtask

  task automatic idle_e();
    ife.alu_valid = 0; ife.alu_rd_address = 0; ife.alu_result = 0;
    ife.load_issue = 0; ife.load_issue_address = 0;
    ife.load_valid = 0; ife.load_rd_address = 0; ife.load_data = 0;
    ife.rs1_address = 0; ife.rs2_address = 0;
  endtask

  task automatic test_reset();
    idle_a(); idle_e();
    @(negedge clock); reset = 0; #1;
    checks++; if (ifa.load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ifa.load_ready); end
    @(posedge clock); #1;
    checks++; if (ifa.rd_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", ifa.rd_write_enable); end
    checks++; if (ifa.rd !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", ifa.rd); end
    checks++; if (ifa.rd_address !== 5'h0) begin errors++; $display("FAIL reset_rd_address: got %h want 0", ifa.rd_address); end
    checks++; if (ifa.busy_vector !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", ifa.busy_vector); end
    checks++; if (ifa.waw_error !== 1'b0) begin errors++; $display("FAIL reset_waw: got %b want 0", ifa.waw_error); end
    @(negedge clock); reset = 1; #1;
    checks++; if (ifa.load_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ifa.load_ready); end
  endtask

  task automatic test_alu_write();
    @(negedge clock); ifa.alu_valid = 1; ifa.alu_rd_address = 5; ifa.alu_result = 32'h12345678;
    @(posedge clock); #1;
    checks++; if (ifa.rd_write_enable !== 1'b1) begin errors++; $display("FAIL alu_we: got %b want 1", ifa.rd_write_enable); end
    checks++; if (ifa.rd_address !== 5'd5) begin errors++; $display("FAIL alu_addr: got %0d want 5", ifa.rd_address); end
    checks++; if (ifa.rd !== 32'h12345678) begin errors++; $display("FAIL alu_rd: got %h want 12345678", ifa.rd); end
    @(negedge clock); idle_a();
    @(posedge clock); #1;
    checks++; if (ifa.rd_write_enable !== 1'b0) begin errors++; $display("FAIL alu_we_drop: got %b want 0", ifa.rd_write_enable); end
    checks++; if (ifa.rd !== 32'h12345678) begin errors++; $display("FAIL alu_rd_hold: got %h want 12345678", ifa.rd); end
  endtask

  task automatic test_load_hazard();
    @(negedge clock); ifa.load_issue = 1; ifa.load_issue_address = 7;
    @(negedge clock); ifa.load_issue = 0; ifa.rs1_address = 7;
    ifa.load_valid = 1; ifa.load_rd_address = 7; ifa.load_data = 32'hDEADBEEF; #1;
    checks++; if (ifa.hazard !== 1'b1) begin errors++; $display("FAIL hazard_set: got %b want 1", ifa.hazard); end
    checks++; if (ifa.busy_vector !== 32'h80) begin errors++; $display("FAIL busy_set: got %h want 00000080", ifa.busy_vector); end
    @(posedge clock); #1;
    checks++; if (ifa.rd_write_enable !== 1'b1 || ifa.rd_address !== 5'd7 || ifa.rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_write: got we=%b a=%0d d=%h want we=1 a=7 d=deadbeef", ifa.rd_write_enable, ifa.rd_address, ifa.rd);
    end
    checks++; if (ifa.hazard !== 1'b1) begin errors++; $display("FAIL hazard_during_we: got %b want 1", ifa.hazard); end
    @(negedge clock); ifa.load_valid = 0;
    @(posedge clock); #1;
    checks++; if (ifa.hazard !== 1'b0) begin errors++; $display("FAIL hazard_clear: got %b want 0", ifa.hazard); end
    checks++; if (ifa.busy_vector !== 32'h0) begin errors++; $display("FAIL busy_clear: got %h want 0", ifa.busy_vector); end
    checks++; if (ifa.waw_error !== 1'b0) begin errors++; $display("FAIL load_waw: got %b want 0", ifa.waw_error); end
    @(negedge clock); idle_a();
  endtask

  task automatic test_collision();
    @(negedge clock); ifa.load_issue = 1; ifa.load_issue_address = 4;
    @(negedge clock); ifa.load_issue_address = 6;
    @(negedge clock); ifa.load_issue = 0;
    ifa.alu_valid = 1; ifa.alu_rd_address = 3; ifa.alu_result = 32'h1;
    ifa.load_valid = 1; ifa.load_rd_address = 4; ifa.load_data = 32'h2;
    @(posedge clock); #1;
    checks++; if (ifa.rd_address !== 5'd3 || ifa.rd !== 32'h1 || ifa.rd_write_enable !== 1'b1) begin
      errors++; $display("FAIL coll_alu_first: got a=%0d d=%h we=%b want a=3 d=1 we=1", ifa.rd_address, ifa.rd, ifa.rd_write_enable);
    end
    checks++; if (ifa.load_ready !== 1'b0) begin errors++; $display("FAIL coll_ready_low: got %b want 0", ifa.load_ready); end
    @(negedge clock); idle_a();
    @(posedge clock); #1;
    checks++; if (ifa.rd_address !== 5'd4 || ifa.rd !== 32'h2 || ifa.rd_write_enable !== 1'b1) begin
      errors++; $display("FAIL coll_skid_drain: got a=%0d d=%h we=%b want a=4 d=2 we=1", ifa.rd_address, ifa.rd, ifa.rd_write_enable);
    end
    checks++; if (ifa.load_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_high: got %b want 1", ifa.load_ready); end
    // skid held across a second ALU write
    @(negedge clock); ifa.alu_valid = 1; ifa.alu_rd_address = 1; ifa.alu_result = 32'h11;
    ifa.load_valid = 1; ifa.load_rd_address = 6; ifa.load_data = 32'h66;
    @(negedge clock); ifa.load_valid = 0; ifa.alu_rd_address = 2; ifa.alu_result = 32'h22;
    @(posedge clock); #1;
    checks++; if (ifa.rd_address !== 5'd2 || ifa.rd !== 32'h22 || ifa.load_ready !== 1'b0) begin
      errors++; $display("FAIL skid_wait: got a=%0d d=%h ready=%b want a=2 d=22 ready=0", ifa.rd_address, ifa.rd, ifa.load_ready);
    end
    @(negedge clock); idle_a();
    @(posedge clock); #1;
    checks++; if (ifa.rd_address !== 5'd6 || ifa.rd !== 32'h66 || ifa.load_ready !== 1'b1) begin
      errors++; $display("FAIL skid_late_drain: got a=%0d d=%h ready=%b want a=6 d=66 ready=1", ifa.rd_address, ifa.rd, ifa.load_ready);
    end
    @(posedge clock); #1;
    checks++; if (ifa.busy_vector !== 32'h0 || ifa.waw_error !== 1'b0 || ifa.rd_write_enable !== 1'b0) begin
      errors++; $display("FAIL coll_end: got busy=%h waw=%b we=%b want 0 0 0", ifa.busy_vector, ifa.waw_error, ifa.rd_write_enable);
    end
  endtask

  task automatic test_x0();
    @(negedge clock); ifa.alu_valid = 1; ifa.alu_rd_address = 0; ifa.alu_result = 32'hFFFF;
    ifa.load_issue = 1; ifa.load_issue_address = 0;
    @(posedge clock); #1;
    checks++; if (ifa.rd_write_enable !== 1'b0 || ifa.busy_vector !== 32'h0) begin
      errors++; $display("FAIL x0_alu: got we=%b busy=%h want 0 0", ifa.rd_write_enable, ifa.busy_vector);
    end
    @(negedge clock); idle_a(); ifa.load_valid = 1; ifa.load_rd_address = 0; ifa.load_data = 32'hAAAA; #1;
    checks++; if (ifa.load_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", ifa.load_ready); end
    @(negedge clock); idle_a();
    @(posedge clock); #1;
    checks++; if (ifa.rd_write_enable !== 1'b0 || ifa.waw_error !== 1'b0 || ifa.rd !== 32'h66 || ifa.rd_address !== 5'd6) begin
      errors++; $display("FAIL x0_load: got we=%b waw=%b d=%h a=%0d want 0 0 66 6", ifa.rd_write_enable, ifa.waw_error, ifa.rd, ifa.rd_address);
    end
  endtask

  task automatic test_waw();
    @(negedge clock); ifa.load_issue = 1; ifa.load_issue_address = 9;
    @(negedge clock); ifa.load_issue = 0; ifa.alu_valid = 1; ifa.alu_rd_address = 9; ifa.alu_result = 32'h99;
    @(posedge clock); #1;
    checks++; if (ifa.rd_write_enable !== 1'b0 || ifa.waw_error !== 1'b1) begin
      errors++; $display("FAIL waw_alu: got we=%b waw=%b want 0 1", ifa.rd_write_enable, ifa.waw_error);
    end
    @(negedge clock); idle_a();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (ifa.waw_error !== 1'b1) begin errors++; $display("FAIL waw_sticky: got %b want 1", ifa.waw_error); end
    @(negedge clock); reset = 0;
    @(posedge clock); #1;
    checks++; if (ifa.waw_error !== 1'b0 || ifa.busy_vector !== 32'h0) begin
      errors++; $display("FAIL waw_reset: got waw=%b busy=%h want 0 0", ifa.waw_error, ifa.busy_vector);
    end
    @(negedge clock); reset = 1;
  endtask

  task automatic test_rv32e();
    @(negedge clock); ife.alu_valid = 1; ife.alu_rd_address = 5'h13; ife.alu_result = 32'h13;
    @(posedge clock); #1;
    checks++; if (ife.rd_write_enable !== 1'b1 || ife.rd_address !== 5'd3 || ife.rd !== 32'h13) begin
      errors++; $display("FAIL e_mask_addr: got we=%b a=%0d d=%h want 1 3 13", ife.rd_write_enable, ife.rd_address, ife.rd);
    end
    @(negedge clock); ife.alu_valid = 0; ife.load_issue = 1; ife.load_issue_address = 5'h1A;
    @(posedge clock); #1;
    checks++; if (ife.busy_vector !== 32'h0000_0400) begin errors++; $display("FAIL e_busy: got %h want 00000400", ife.busy_vector); end
    @(negedge clock); ife.load_issue = 0; ife.alu_valid = 1; ife.alu_rd_address = 1; ife.alu_result = 32'h1;
    ife.load_valid = 1; ife.load_rd_address = 5'h1A; ife.load_data = 32'hA;
    @(posedge clock); #1;
    checks++; if (ife.load_ready !== 1'b0) begin errors++; $display("FAIL e_skid_full: got ready=%b want 0", ife.load_ready); end
    @(negedge clock); idle_e(); reset = 0;
    @(posedge clock); #1;
    checks++; if (ife.busy_vector !== 32'h0 || ife.rd_write_enable !== 1'b0) begin
      errors++; $display("FAIL e_reset: got busy=%h we=%b want 0 0", ife.busy_vector, ife.rd_write_enable);
    end
    @(negedge clock); reset = 1; #1;
    checks++; if (ife.load_ready !== 1'b1) begin errors++; $display("FAIL e_skid_empty: got ready=%b want 1", ife.load_ready); end
    @(posedge clock); #1;
    checks++; if (ife.rd_write_enable !== 1'b0) begin errors++; $display("FAIL e_skid_discard: got we=%b want 0", ife.rd_write_enable); end
  endtask

  task automatic test_random();
    bit          mb[32];
    logic [4:0]  sq_a[$];
    logic [31:0] sq_d[$];
    logic [4:0]  out_q[$];
    bit          ret_active;
    logic [4:0]  ret_a;
    logic [31:0] ret_d;
    logic [31:0] m_rd;
    logic [4:0]  m_addr;
    bit          m_we, m_waw, clr_v, acc, exp_hz, w_en, w_load, iss;
    logic [4:0]  clr_a, a_addr, i_addr, r1, r2, w_addr;
    logic [31:0] a_data, w_data, exp_bv;
    @(negedge clock); idle_a(); reset = 0;
    @(negedge clock); reset = 1;
    foreach (mb[i]) mb[i] = 0;
    ret_active = 0; ret_a = 0; ret_d = 0;
    m_rd = 0; m_addr = 0; m_we = 0; m_waw = 0; clr_v = 0; clr_a = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      a_addr = 5'($urandom_range(0, 31)); a_data = $urandom;
      i_addr = 5'($urandom_range(0, 31)); iss = ($urandom_range(0, 3) == 0);
      r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31));
      if (!ret_active && out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        ret_active = 1; ret_a = out_q.pop_front(); ret_d = $urandom;
      end
      if (iss) out_q.push_back(i_addr);
      ifa.alu_valid = ($urandom_range(0, 2) == 0); ifa.alu_rd_address = a_addr; ifa.alu_result = a_data;
      ifa.load_issue = iss; ifa.load_issue_address = i_addr;
      ifa.load_valid = ret_active; ifa.load_rd_address = ret_a; ifa.load_data = ret_d;
      ifa.rs1_address = r1; ifa.rs2_address = r2;
      #1;
      exp_hz = (r1 != 0 && mb[r1]) || (r2 != 0 && mb[r2]);
      checks++; if (ifa.hazard !== exp_hz) begin errors++; $display("FAIL rnd_hazard cyc %0d: got %b want %b", cyc, ifa.hazard, exp_hz); end
      checks++; if (ifa.load_ready !== (sq_a.size() == 0)) begin
        errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, ifa.load_ready, sq_a.size() == 0);
      end
      acc = ret_active && (sq_a.size() == 0);
      w_en = 0; w_load = 0; w_addr = 0; w_data = 0;
      if (ifa.alu_valid) begin
        if (mb[a_addr]) m_waw = 1;
        else if (a_addr != 0) begin w_en = 1; w_addr = a_addr; w_data = a_data; end
        if (acc) begin sq_a.push_back(ret_a); sq_d.push_back(ret_d); end
      end else if (sq_a.size() > 0) begin
        w_addr = sq_a.pop_front(); w_data = sq_d.pop_front(); w_load = 1; w_en = (w_addr != 0);
      end else if (acc) begin
        w_addr = ret_a; w_data = ret_d; w_load = 1; w_en = (ret_a != 0);
      end
      if (acc && ret_a != 0 && !mb[ret_a]) m_waw = 1;
      if (iss && i_addr != 0 && mb[i_addr]) m_waw = 1;
      if (clr_v) mb[clr_a] = 0;
      if (iss && i_addr != 0) mb[i_addr] = 1;
      clr_v = w_en && w_load; clr_a = w_addr;
      m_we = w_en;
      if (w_en) begin m_rd = w_data; m_addr = w_addr; end
      if (acc) ret_active = 0;
      foreach (mb[i]) exp_bv[i] = mb[i];
      @(posedge clock); #1;
      checks++; if (ifa.rd_write_enable !== m_we || ifa.rd_address !== m_addr || ifa.rd !== m_rd) begin
        errors++; $display("FAIL rnd_write cyc %0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                           cyc, ifa.rd_write_enable, ifa.rd_address, ifa.rd, m_we, m_addr, m_rd);
      end
      checks++; if (ifa.busy_vector !== exp_bv) begin errors++; $display("FAIL rnd_busy cyc %0d: got %h want %h", cyc, ifa.busy_vector, exp_bv); end
      checks++; if (ifa.waw_error !== m_waw) begin errors++; $display("FAIL rnd_waw cyc %0d: got %b want %b", cyc, ifa.waw_error, m_waw); end
    end
    @(negedge clock); idle_a();
  endtask

  initial begin
    idle_a(); idle_e();
    test_reset();
    test_alu_write();
    test_load_hazard();
    test_collision();
    test_x0();
    test_waw();
    test_rv32e();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
